// File: rtl/two_bit_count_pkg.sv
// Shared types and constants for the two-bit counter sequence checker.
// State encoding, lock length default and the mod-4 successor helper.
package two_bit_count_pkg;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] ACQ_ENC  = 2'd1;
   localparam logic [1:0] LOCK_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      ACQ  = ACQ_ENC,
      LOCK = LOCK_ENC
   } state_e;

   localparam int LOCK_LEN_DEF = 4;
   localparam int RUN_W        = 4;

   function automatic logic [1:0] succ(input logic [1:0] v);
      return v + 2'd1;
   endfunction

endpackage

// File: rtl/two_bit_count_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear beats increment; reset beats both.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/two_bit_count_checker.sv
// Checks that a sampled 2-bit counter steps +1 mod 4 once locked.
// Flags out-of-sequence samples and 3->0 wraps with one-cycle pulses.
module two_bit_count_checker #(
   parameter int LOCK_LEN = two_bit_count_pkg::LOCK_LEN_DEF,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample,
   input  logic [1:0]       count_in,
   input  logic             clear,
   output logic             locked,
   output logic             seq_err,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   import two_bit_count_pkg::*;

   localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

   state_e           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             locked_q, locked_d;
   logic             seq_err_q, seq_err_d;
   logic             wrap_q, wrap_d;

   logic             correct;
   logic [RUN_W-1:0] run_inc;

   assign correct = (count_in == succ(prev_q));
   assign run_inc = run_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      run_d     = run_q;
      seq_err_d = 1'b0;
      wrap_d    = 1'b0;
      if (sample) begin
         unique case (state_q)
            IDLE: begin
               prev_d  = count_in;
               run_d   = '0;
               state_d = ACQ;
            end
            ACQ: begin
               prev_d = count_in;
               if (correct) begin
                  run_d = run_inc;
                  if (run_inc == LOCK_RUN) begin
                     state_d = LOCK;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCK: begin
               prev_d = count_in;
               if (correct) begin
                  wrap_d = (prev_q == 2'd3);
               end else begin
                  seq_err_d = 1'b1;
                  run_d     = '0;
                  state_d   = ACQ;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (state_q == LOCK_ENC + 2'd1) begin
         // unused encoding recovers even without a sample
         state_d = IDLE;
      end
      locked_d = (state_d == LOCK);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         run_q     <= '0;
         locked_q  <= 1'b0;
         seq_err_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         locked_q  <= locked_d;
         seq_err_q <= seq_err_d;
         wrap_q    <= wrap_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_wrap_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wrap_d),
      .clr   (clear),
      .count (wrap_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (seq_err_d),
      .clr   (clear),
      .count (err_cnt)
   );

   assign locked     = locked_q;
   assign seq_err    = seq_err_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_two_bit_count_checker.sv
// Bench for two_bit_count_checker: three parameterisations driven in lockstep.
// Expectations come from a streak-based reference model.
module tb_two_bit_count_checker;

   logic       clock;
   logic       reset;
   logic       sample;
   logic [1:0] count_in;
   logic       clear;

   logic       lk_a, se_a, wp_a;
   logic [7:0] wc_a, ec_a;
   logic       lk_b, se_b, wp_b;
   logic [1:0] wc_b, ec_b;
   logic       lk_c, se_c, wp_c;
   logic [7:0] wc_c, ec_c;

   int n_pass;
   int n_total;

   int    lim_l [3] = '{4, 4, 1};
   int    lim_w [3] = '{8, 2, 8};
   bit    seeded [3];
   int    streak [3];
   int    prv    [3];
   bit    e_lk   [3];
   bit    e_se   [3];
   bit    e_wp   [3];
   longint e_wc  [3];
   longint e_ec  [3];

   two_bit_count_checker #(.LOCK_LEN(4), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .sample(sample),
      .count_in(count_in), .clear(clear),
      .locked(lk_a), .seq_err(se_a), .wrap_pulse(wp_a),
      .wrap_cnt(wc_a), .err_cnt(ec_a)
   );

   two_bit_count_checker #(.LOCK_LEN(4), .CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .sample(sample),
      .count_in(count_in), .clear(clear),
      .locked(lk_b), .seq_err(se_b), .wrap_pulse(wp_b),
      .wrap_cnt(wc_b), .err_cnt(ec_b)
   );

   two_bit_count_checker #(.LOCK_LEN(1), .CNT_W(8)) dut_c (
      .clock(clock), .reset(reset), .sample(sample),
      .count_in(count_in), .clear(clear),
      .locked(lk_c), .seq_err(se_c), .wrap_pulse(wp_c),
      .wrap_cnt(wc_c), .err_cnt(ec_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Locked means the last LOCK_LEN or more samples were all correct steps.
   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            seeded[i] = 1'b0;
            streak[i] = 0;
            prv[i]    = 0;
            e_se[i]   = 1'b0;
            e_wp[i]   = 1'b0;
            e_wc[i]   = 0;
            e_ec[i]   = 0;
         end else begin
            longint mx;
            bit was_lock;
            e_se[i] = 1'b0;
            e_wp[i] = 1'b0;
            if (sample) begin
               if (!seeded[i]) begin
                  seeded[i] = 1'b1;
                  streak[i] = 0;
               end else begin
                  was_lock = (streak[i] >= lim_l[i]);
                  if (int'(count_in) == (prv[i] + 1) % 4) begin
                     e_wp[i] = was_lock && (prv[i] == 3);
                     if (streak[i] < 100) streak[i]++;
                  end else begin
                     e_se[i]   = was_lock;
                     streak[i] = 0;
                  end
               end
               prv[i] = int'(count_in);
            end
            mx = (64'd1 << lim_w[i]) - 1;
            if (clear) begin
               e_wc[i] = 0;
               e_ec[i] = 0;
            end else begin
               if (e_wp[i] && e_wc[i] < mx) e_wc[i]++;
               if (e_se[i] && e_ec[i] < mx) e_ec[i]++;
            end
         end
         e_lk[i] = seeded[i] && (streak[i] >= lim_l[i]);
      end
   endtask

   task automatic compare_all();
      check("a.locked", lk_a, e_lk[0]);
      check("a.seq_err", se_a, e_se[0]);
      check("a.wrap", wp_a, e_wp[0]);
      check("a.wrap_cnt", wc_a, e_wc[0]);
      check("a.err_cnt", ec_a, e_ec[0]);
      check("b.locked", lk_b, e_lk[1]);
      check("b.seq_err", se_b, e_se[1]);
      check("b.wrap", wp_b, e_wp[1]);
      check("b.wrap_cnt", wc_b, e_wc[1]);
      check("b.err_cnt", ec_b, e_ec[1]);
      check("c.locked", lk_c, e_lk[2]);
      check("c.seq_err", se_c, e_se[2]);
      check("c.wrap", wp_c, e_wp[2]);
      check("c.wrap_cnt", wc_c, e_wc[2]);
      check("c.err_cnt", ec_c, e_ec[2]);
   endtask

   task automatic step(input logic s, input logic [1:0] c,
                       input logic clr, input logic rst);
      @(negedge clock);
      sample   = s;
      count_in = c;
      clear    = clr;
      reset    = rst;
      @(posedge clock);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic feed(input int v);
      step(1'b1, 2'(v), 1'b0, 1'b0);
   endtask

   initial begin
      int seq [5];
      n_pass   = 0;
      n_total  = 0;
      sample   = 1'b0;
      count_in = 2'd0;
      clear    = 1'b0;
      reset    = 1'b1;

      step(1'b0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      check("reset.locked", lk_a, 1'b0);
      check("reset.err_cnt", ec_a, 8'd0);

      seq = '{0, 1, 2, 3, 0};
      foreach (seq[k]) feed(seq[k]);
      check("lock.after5", lk_a, 1'b1);
      check("lock.no_err", se_a, 1'b0);

      seq = '{1, 2, 3, 0, 1};
      foreach (seq[k]) feed(seq[k]);
      check("wrap.cnt1", wc_a, 8'd1);
      check("wrap.err0", ec_a, 8'd0);

      feed(2);
      feed(0);
      check("err.pulse", se_a, 1'b1);
      check("err.cnt1", ec_a, 8'd1);
      check("err.unlock", lk_a, 1'b0);
      seq = '{1, 2, 3, 0, 0};
      for (int k = 0; k < 4; k++) feed(seq[k]);
      check("relock", lk_a, 1'b1);

      feed(1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      check("midlock_rst.locked", lk_a, 1'b0);
      check("midlock_rst.wrap_cnt", wc_a, 8'd0);
      feed(3);
      check("seed_only.err", se_a, 1'b0);
      seq = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 4; k++) feed(seq[k]);
      check("seed3.lock", lk_a, 1'b1);

      for (int k = 0; k < 10; k++) begin
         step(1'b0, 2'(k), 1'b0, 1'b0);
      end
      check("idle.locked", lk_a, 1'b1);

      step(1'b0, 2'd0, 1'b0, 1'b1);
      for (int r = 0; r < 5; r++) begin
         foreach (seq[k]) feed(seq[k]);
         if (r == 4) check("sat.hold3", ec_b, 2'd3);
         step(1'b1, 2'd2, (r == 4), 1'b0);
      end
      check("clr_wins.cnt", ec_b, 2'd0);
      check("clr_wins.pulse", se_b, 1'b1);

      for (int n = 0; n < 1500; n++) begin
         logic       s, clr, rst;
         logic [1:0] c;
         rst = ($urandom % 64) == 0;
         s   = ($urandom % 4) != 0;
         clr = ($urandom % 32) == 0;
         if (($urandom % 6) != 0) c = 2'((prv[0] + 1) % 4);
         else c = 2'($urandom);
         step(s, c, clr, rst);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
